lsu_mem_ctrl: RTL and testbench
===============================

LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 SHALL have ports: clk input 1 clock; rst input 1 reset, asynchronous, active-low.
REQ-002 SHALL have ports: load input 1 load request; store input 1 store request; funct3 input 3 access size/sign; addr input 32 byte address; wdata input 32 store data.
REQ-003 SHALL have ports: valid output 1 load-data-ready pulse; rdata output 32 extended load data; busy output 1 access in flight.
REQ-004 SHALL have ports: mem_req output 1; mem_we output 1; mem_addr output 32 word-aligned; mem_wdata output 32; mem_wstrb output 4; mem_ack input 1; mem_rdata input 32.
REQ-005 SHALL have port misalign output 1, present only when LSU_MISALIGN_TRAP_EN is defined.

Function
REQ-006 SHALL implement FSM with states IDLE, BUSY and DONE; busy SHALL be 1 in any state other than IDLE.
REQ-007 IDLE: load=1 SHALL capture addr/funct3, set mem_we=0 and enter BUSY; else store=1 SHALL capture addr/funct3/wdata, set mem_we=1 and enter BUSY; else stay in IDLE.
REQ-008 If load and store are both 1, the access SHALL be treated as a load.
REQ-009 In BUSY, mem_req SHALL be 1 and mem_addr, mem_we, mem_wdata and mem_wstrb SHALL be held stable until mem_ack=1.
REQ-010 Load in BUSY with mem_ack=1 SHALL register the extended data into rdata and enter DONE.
REQ-011 Store in BUSY with mem_ack=1 SHALL return to IDLE; stores SHALL never assert valid.
REQ-012 DONE SHALL last exactly 1 cycle with valid=1, then return to IDLE.
REQ-013 load and store SHALL be ignored in BUSY and DONE, with no queuing.
REQ-014 Minimum load latency (load sampled in IDLE at cycle 0, mem_ack=1 at cycle 1) SHALL give valid=1 at cycle 2; each extra wait cycle SHALL add 1 cycle.
REQ-015 valid SHALL be 0 whenever a load is pending, so a consumer stalling on load & !valid holds.
REQ-016 mem_addr SHALL equal {addr[31:2], 2'b00}.
REQ-017 Stores SHALL use: SB mem_wstrb = 0001<<addr[1:0], mem_wdata = byte replicated x4; SH mem_wstrb = 0011<<(2*addr[1]), half replicated x2; SW 1111, wdata unchanged.
REQ-018 Loads SHALL select byte/half from mem_rdata by addr[1:0]: LB 000 sign-extend byte, LH 001 sign-extend half, LW 010 word, LBU 100 zero-extend byte, LHU 101 zero-extend half.
REQ-019 Other funct3 codes SHALL be treated as a word access (LW/SW).
REQ-020 rdata SHALL hold its last value outside DONE.

Reset
REQ-021 rst=0 SHALL immediately force state IDLE, valid=0, rdata=0, busy=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0 and misalign=0.
REQ-022 Reset mid-access SHALL abandon the transaction, with no valid pulse afterwards; a late mem_ack after reset SHALL be ignored.

Configuration
REQ-023 LSU_MISALIGN_TRAP_EN defined: a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL skip BUSY with no mem_req, pulse misalign=1 for 1 cycle, and go IDLE->IDLE for a store or IDLE->DONE with rdata=0 and valid=1 for a load.
REQ-024 LSU_MISALIGN_TRAP_EN undefined: misalign port SHALL be absent; half accesses SHALL ignore addr[0], word accesses SHALL ignore addr[1:0], and the bus access SHALL proceed normally.

Verification
REQ-025 LB addr=0x103, mem_rdata=0x80FF_1234, ack at first mem_req cycle -> mem_addr=0x100, valid cycle 2, rdata=0xFFFF_FF80.
REQ-026 SH addr=0x202, wdata=0x0000_BEEF, ack after 3 wait cycles -> mem_wstrb=1100, mem_wdata=0xBEEF_BEEF, mem_req held 4 cycles, valid stays 0.
REQ-027 LHU addr=0x2, mem_rdata=0xA5A5_0000, load held high until valid -> rdata=0x0000_A5A5, exactly one valid pulse, no second mem_req.
REQ-028 load=store=1, funct3=010, addr=0x40 -> mem_we=0, load completes, no write strobe.
REQ-029 rst=0 while BUSY, then mem_ack=1 after release -> mem_req=0 immediately, valid never 1, busy=0.
REQ-030 With LSU_MISALIGN_TRAP_EN, LW addr=0x41 -> mem_req never 1, misalign=1 and valid=1 same cycle, rdata=0.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit to single-port memory bus bridge: sizes, aligns and extends accesses.
// Optional trap on misaligned half/word accesses when LSU_MISALIGN_TRAP_EN is defined.
module lsu_mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        valid,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [1:0]  req_off;
  logic [2:0]  req_f3;
  logic        trap;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] ld_data;

  assign mem_req = (state == BUSY);
  assign busy    = (state != IDLE);
  assign valid   = (state == DONE);

  // Misaligned accesses are only detected when the trap feature is built in.
  always_comb begin
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (load) begin
      if (funct3 == 3'b001 || funct3 == 3'b101)
        trap = addr[0];
      else if (funct3 != 3'b000 && funct3 != 3'b100)
        trap = |addr[1:0];
    end else if (store) begin
      if (funct3 == 3'b001)
        trap = addr[0];
      else if (funct3 != 3'b000)
        trap = |addr[1:0];
    end
`endif
  end

  always_comb begin
    st_wdata = wdata;
    st_wstrb = 4'b1111;
    case (funct3)
      3'b000: begin
        st_wdata = {4{wdata[7:0]}};
        st_wstrb = 4'b0001 << addr[1:0];
      end
      3'b001: begin
        st_wdata = {2{wdata[15:0]}};
        st_wstrb = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    lane_byte = mem_rdata[7:0];
    case (req_off)
      2'd1:    lane_byte = mem_rdata[15:8];
      2'd2:    lane_byte = mem_rdata[23:16];
      2'd3:    lane_byte = mem_rdata[31:24];
      default: lane_byte = mem_rdata[7:0];
    endcase
    lane_half = req_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (req_f3)
      3'b000:  ld_data = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  ld_data = {{16{lane_half[15]}}, lane_half};
      3'b100:  ld_data = {24'h000000, lane_byte};
      3'b101:  ld_data = {16'h0000, lane_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (load || store) begin
          if (trap)
            next_state = load ? DONE : IDLE;
          else
            next_state = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack)
          next_state = mem_we ? IDLE : DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Bus fields are captured once in IDLE so they stay frozen for the whole BUSY phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_off   <= 2'd0;
      req_f3    <= 3'd0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_wstrb <= 4'h0;
      rdata     <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (load || store) begin
            req_off  <= addr[1:0];
            req_f3   <= funct3;
            mem_addr <= {addr[31:2], 2'b00};
            mem_we   <= !load;
            if (load) begin
              mem_wdata <= 32'h0;
              mem_wstrb <= 4'h0;
              if (trap)
                rdata <= 32'h0;
            end else begin
              mem_wdata <= st_wdata;
              mem_wstrb <= st_wstrb;
            end
          end
        end
        BUSY: begin
          if (mem_ack && !mem_we)
            rdata <= ld_data;
        end
        default: ;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      misalign <= 1'b0;
    else
      misalign <= (state == IDLE) && (load || store) && trap;
  end
`endif

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed scenarios plus randomized accesses
// compared against an arithmetic model of the access rules.
module tb_lsu_mem_ctrl;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        load;
  logic        store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        valid;
  logic [31:0] rdata;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int          check_count;
  int          pass_count;
  int          fail_count;
  logic [31:0] last_rdata;

  lsu_mem_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .store     (store),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .valid     (valid),
    .rdata     (rdata),
    .busy      (busy),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ack   (mem_ack),
`ifdef LSU_MISALIGN_TRAP_EN
    .misalign  (misalign),
`endif
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] shifted;
    int          v;
    case (f3)
      3'd0, 3'd4: begin
        shifted = rd >> (8 * a[1:0]);
        v = int'(shifted & 32'hFF);
        if (f3 == 3'd0 && v >= 128) v = v - 256;
        return 32'(v);
      end
      3'd1, 3'd5: begin
        shifted = rd >> (16 * a[1]);
        v = int'(shifted & 32'hFFFF);
        if (f3 == 3'd1 && v >= 32768) v = v - 65536;
        return 32'(v);
      end
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'd0:    return 4'(1 << a[1:0]);
      3'd1:    return a[1] ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'd0:    return (wd & 32'hFF) * 32'h01010101;
      3'd1:    return (wd & 32'hFFFF) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic bit model_misaligned(input bit is_ld, input logic [2:0] f3, input logic [31:0] a);
    bit is_half;
    bit is_byte;
    is_half = is_ld ? (f3 == 3'd1 || f3 == 3'd5) : (f3 == 3'd1);
    is_byte = is_ld ? (f3 == 3'd0 || f3 == 3'd4) : (f3 == 3'd0);
    if (is_half) return TRAP_EN && a[0];
    if (is_byte) return 1'b0;
    return TRAP_EN && (a[1:0] != 2'b00);
  endfunction

  // mode 0: request dropped after acceptance, 1: held until completion, 2: random noise while busy
  task automatic apply_stimulus(input bit do_load, input bit do_store, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                                input int waits, input int mode);
    bit          is_ld;
    logic [31:0] exp_addr;
    logic [3:0]  exp_strb;
    is_ld    = do_load;
    exp_addr = a & 32'hFFFF_FFFC;
    exp_strb = is_ld ? 4'h0 : model_strb(f3, a);
    load = do_load; store = do_store; funct3 = f3; addr = a; wdata = wd; mem_ack = 1'b0;
    @(negedge clk);
    if (model_misaligned(is_ld, f3, a)) begin
      load = 1'b0; store = 1'b0;
      check_output("trap_mem_req", mem_req, 0);
`ifdef LSU_MISALIGN_TRAP_EN
      check_output("trap_misalign", misalign, 1);
`endif
      if (is_ld) begin
        last_rdata = 32'h0;
        check_output("trap_valid", valid, 1);
        check_output("trap_rdata", rdata, 0);
      end else begin
        check_output("trap_st_valid", valid, 0);
        check_output("trap_st_busy", busy, 0);
      end
      @(negedge clk);
      check_output("trap_after_valid", valid, 0);
      check_output("trap_after_req", mem_req, 0);
`ifdef LSU_MISALIGN_TRAP_EN
      check_output("trap_after_misalign", misalign, 0);
`endif
      return;
    end
    if (mode == 0) begin load = 1'b0; store = 1'b0; end
    for (int i = 0; i <= waits; i++) begin
      check_output("busy_mem_req", mem_req, 1);
      check_output("busy_busy", busy, 1);
      check_output("busy_valid", valid, 0);
      check_output("busy_mem_addr", mem_addr, exp_addr);
      check_output("busy_mem_we", mem_we, !is_ld);
      check_output("busy_mem_wstrb", mem_wstrb, exp_strb);
      if (!is_ld) check_output("busy_mem_wdata", mem_wdata, model_wdata(f3, wd));
      if (mode == 2) begin
        load = 1'($urandom); store = 1'($urandom); funct3 = 3'($urandom);
        addr = $urandom; wdata = $urandom;
      end
      mem_ack   = (i == waits);
      mem_rdata = (i == waits) ? rd : $urandom;
      @(negedge clk);
    end
    mem_ack = 1'b0; mem_rdata = $urandom;
    if (is_ld) begin
      last_rdata = model_load(f3, a, rd);
      check_output("done_valid", valid, 1);
      check_output("done_busy", busy, 1);
      check_output("done_mem_req", mem_req, 0);
      check_output("done_rdata", rdata, last_rdata);
      @(negedge clk);
    end
    load = 1'b0; store = 1'b0;
    check_output("idle_valid", valid, 0);
    check_output("idle_busy", busy, 0);
    check_output("idle_mem_req", mem_req, 0);
    check_output("idle_rdata_hold", rdata, last_rdata);
    @(negedge clk);
    check_output("idle2_mem_req", mem_req, 0);
    check_output("idle2_valid", valid, 0);
  endtask

  initial begin
    check_count = 0; pass_count = 0; fail_count = 0; last_rdata = 32'h0;
    rst = 1'b0; load = 1'b0; store = 1'b0; funct3 = 3'd0; addr = 32'h0; wdata = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    check_output("rst_valid", valid, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_mem_req", mem_req, 0);
    check_output("rst_mem_addr", mem_addr, 0);
    check_output("rst_rdata", rdata, 0);
    check_output("rst_mem_wstrb", mem_wstrb, 0);
    rst = 1'b1;
    @(negedge clk);

    apply_stimulus(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 0);
    check_output("lb_value", last_rdata, 32'hFFFF_FF80);
    apply_stimulus(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 32'h0, 3, 0);
    apply_stimulus(1'b1, 1'b0, 3'b101, 32'h0000_0002, 32'h0, 32'hA5A5_0000, 1, 1);
    check_output("lhu_value", last_rdata, 32'h0000_A5A5);
    apply_stimulus(1'b1, 1'b1, 3'b010, 32'h0000_0040, 32'h1234_5678, 32'hCAFE_F00D, 2, 0);
    apply_stimulus(1'b1, 1'b0, 3'b010, 32'h0000_0041, 32'h0, 32'h5555_AAAA, 0, 0);

    // Reset in the middle of a load, then a stale acknowledge
    load = 1'b1; funct3 = 3'b010; addr = 32'h0000_0080;
    @(negedge clk);
    load = 1'b0;
    check_output("mid_mem_req", mem_req, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    last_rdata = 32'h0;
    check_output("mid_rst_mem_req", mem_req, 0);
    check_output("mid_rst_busy", busy, 0);
    check_output("mid_rst_valid", valid, 0);
    check_output("mid_rst_mem_addr", mem_addr, 0);
    check_output("mid_rst_rdata", rdata, 0);
    @(negedge clk);
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("late_ack_valid", valid, 0);
      check_output("late_ack_busy", busy, 0);
      check_output("late_ack_mem_req", mem_req, 0);
    end
    mem_ack = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 60; n++) begin
      bit ld;
      ld = 1'($urandom);
      apply_stimulus(ld, !ld || 1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                     int'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1) ? 2 : 0);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
